// File: rtl/reg_file_dump.sv
// reg_file_dump: halts the core and streams x0..x31 out as a framed
// byte sequence: header, 4 LE bytes per register, XOR checksum.
module reg_file_dump #(
  parameter int          NUM_REGS = 32,
  parameter int          ADDR_W   = 5,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              halt_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_LOAD,
    S_SEND,
    S_TRAILER,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic [31:0]       shift, shift_n;
  logic [7:0]        csum, csum_n;
  logic [7:0]        tx_data_n;
  logic              tx_valid_n;
  logic [31:0]       ld_word;

  // x0 is hardwired to zero, so its read data is never trusted.
  assign ld_word = (idx == '0) ? 32'd0 : rd_data;

  assign rd_addr  = idx;
  assign busy     = (state == S_HEADER) || (state == S_LOAD) ||
                    (state == S_SEND)   || (state == S_TRAILER);
  assign halt_req = busy;
  assign done     = (state == S_DONE);

  // State and datapath registers; tx_* are registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      byte_cnt <= '0;
      shift    <= '0;
      csum     <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      byte_cnt <= byte_cnt_n;
      shift    <= shift_n;
      csum     <= csum_n;
      tx_data  <= tx_data_n;
      tx_valid <= tx_valid_n;
    end
  end

  // Next-state and next-output logic; nothing moves while a byte stalls.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    byte_cnt_n = byte_cnt;
    shift_n    = shift;
    csum_n     = csum;
    tx_data_n  = tx_data;
    tx_valid_n = tx_valid;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n    = S_HEADER;
          idx_n      = '0;
          byte_cnt_n = '0;
          csum_n     = '0;
          tx_data_n  = HEADER;
          tx_valid_n = 1'b1;
        end
      end
      S_HEADER: begin
        if (tx_ready) begin
          state_n    = S_LOAD;
          tx_valid_n = 1'b0;
        end
      end
      S_LOAD: begin
        shift_n    = ld_word;
        byte_cnt_n = '0;
        tx_data_n  = ld_word[7:0];
        tx_valid_n = 1'b1;
        state_n    = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          csum_n     = csum ^ shift[7:0];
          shift_n    = shift >> 8;
          byte_cnt_n = byte_cnt + 2'd1;
          tx_data_n  = shift[15:8];
          if (byte_cnt == 2'd3) begin
            if (idx == LAST) begin
              state_n   = S_TRAILER;
              tx_data_n = csum_n;
            end else begin
              idx_n      = idx + ADDR_W'(1);
              state_n    = S_LOAD;
              tx_valid_n = 1'b0;
            end
          end
        end
      end
      S_TRAILER: begin
        if (tx_ready) begin
          state_n    = S_DONE;
          tx_valid_n = 1'b0;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n    = S_IDLE;
        tx_valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/reg_file_dump.md
# reg_file_dump

Debug readout engine that reads the 32-entry integer register file out over a byte stream. On a start pulse it halts the core, walks addresses x0..x31 through a dedicated read port, and sends the frame out over a valid/ready byte interface. The frame is a header byte, every register as 4 little-endian bytes, and an XOR checksum byte. It sits between the register file's debug read port and the UART/debug transmitter.

## Interface
- NUM_REGS, 32, number of registers dumped (addresses 0..NUM_REGS-1)
- ADDR_W, 5, register address width
- HEADER, 8'hA5, frame header byte
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin dump; sampled only in IDLE
- halt_req  out  1  freeze core so register contents stay stable during dump
- rd_addr  out  ADDR_W  register file read address
- rd_data  in  32  register file read data, combinational from rd_addr
- tx_data  out  8  stream byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts byte
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse, frame complete

## Operation
- States: IDLE, HEADER, LOAD, SEND, TRAILER, DONE.
- IDLE: start=1 at an edge -> HEADER, idx=0, byte_cnt=0, csum=0.
- HEADER: tx_data=HEADER, tx_valid=1. On accept -> LOAD. The header is excluded from csum.
- LOAD: tx_valid=0, rd_addr=idx. Capture shift=rd_data, or 0 when idx==0 regardless of rd_data, since x0 reads zero. Then go to SEND with byte_cnt=0.
- SEND: tx_data=shift[7:0], tx_valid=1. On accept:
  - csum ^= shift[7:0]; shift >>= 8; byte_cnt++.
  - When byte_cnt was 3: go to TRAILER if idx==NUM_REGS-1, else idx++ and go to LOAD.
- TRAILER: tx_data=csum (XOR of all 4*NUM_REGS data bytes), tx_valid=1. On accept -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- busy = halt_req = 1 in HEADER, LOAD, SEND and TRAILER; 0 in IDLE and DONE.
- rd_addr always drives idx, including in IDLE.
- start outside IDLE, including in the DONE cycle, is ignored, not queued.
- Byte count: the frame is exactly 4*NUM_REGS+2 bytes (130 at the default).

## Timing
- Reset (async, any state): state=IDLE; idx=0, rd_addr=0, tx_data=0, tx_valid=0, halt_req=0, busy=0, done=0, csum=0.
  - A partial frame is abandoned. The sink resynchronises on the next HEADER.
- A byte transfers at a rising edge where tx_valid && tx_ready.
- While tx_valid=1 and tx_ready=0: tx_data and tx_valid hold stable; no state change.
- tx_valid never drops without a transfer, except through reset.
- tx_valid and tx_data are registered outputs; no combinational path from tx_ready to them.
- With tx_ready held 1, start sampled at edge 0:
  - HEADER occupies cycle 1.
  - Register i uses LOAD at cycle 2+5i and SEND at cycles 3+5i..6+5i.
  - TRAILER occupies cycle 162; done=1 in cycle 163; total 5*NUM_REGS+3 cycles.
- halt_req rises the cycle after start is sampled. It falls in the DONE cycle.
- rd_data is sampled only in LOAD, one cycle after rd_addr is stable (rd_addr changes on the SEND->LOAD edge).

## Test plan
- Reset check: assert rst mid-cycle with no clock -> all outputs 0 immediately. Deassert and idle 10 cycles with start=0 -> tx_valid stays 0.
- Full dump, no backpressure:
  - Stimulus: rd_data model = 32'h1000_0000+addr, tx_ready=1, start pulse.
  - Required stream: A5, 00 00 00 00, 01 00 00 10, 02 00 00 10, …, 1F 00 00 10, checksum 10.
  - Required totals: 130 bytes; done in cycle 163; halt_req high for cycles 1..162.
- x0 masking: model returns 32'hFFFF_FFFF for addr 0 -> bytes 2-5 are 00. Checksum excludes FF.
- Backpressure:
  - Stimulus: pseudo-random tx_ready (~50%), plus ready held 0 for 20 cycles during register 7 byte 2.
  - Required: tx_data stable while stalled; byte stream identical to the no-backpressure case; no byte dropped or duplicated.
- Ignored start: pulse start during SEND of register 3 and again in the DONE cycle -> exactly one 130-byte frame; returns to IDLE.
- Reset mid-dump: assert rst after byte 50 -> tx_valid=0 and halt_req=0 immediately. A new start then produces a complete frame beginning with A5 and the correct checksum.
